// File: rtl/rv_lsu.sv
// rv_lsu: sequential load/store unit between the core memory stage and a
// word-wide data-memory port with a req/ack handshake.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid / req_ready       core request handshake (one request at a time)
//   req_we, req_funct3          store flag and RISC-V funct3 of the access
//   req_addr, req_wdata         byte address, right-aligned store data
//   rsp_valid                   one-cycle response strobe
//   rsp_rdata, rsp_err          extended load data (0 for stores/errors), error flag
//   mem_req / mem_ack           bus request held until acknowledge
//   mem_we, mem_addr, mem_be    bus write flag, word-aligned address, byte enables
//   mem_wdata / mem_rdata       lane-shifted store data / bus read data
module rv_lsu #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_rdata,
   output logic                rsp_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_ack,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

   state_e             state_q;
   logic               req_ready_q, rsp_valid_q, rsp_err_q;
   logic               mem_req_q, mem_we_q;
   logic [XLEN-1:0]    rsp_rdata_q, mem_wdata_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [NB-1:0]      mem_be_q;
   logic [7:0]         wait_q;
   logic [2:0]         funct3_q;
   logic [OFF_W-1:0]   off_q;

   // Request decode (combinational on the incoming request)
   logic [1:0]         sz;
   logic [OFF_W-1:0]   req_off;
   logic               legal, misal;
   logic [NB-1:0]      size_mask, be_d;
   logic [XLEN-1:0]    wdata_d;
   logic [ADDR_W-1:0]  addr_d;

   always_comb begin
      sz      = req_funct3[1:0];
      req_off = req_addr[OFF_W-1:0];

      if (req_we) begin
         legal = !req_funct3[2] && ((sz != 2'd3) || (XLEN == 64));
      end else begin
         legal = (req_funct3 != 3'b111) &&
                 !((req_funct3 == 3'b011 || req_funct3 == 3'b110) && (XLEN != 64));
      end

      case (sz)
         2'd0:    misal = 1'b0;
         2'd1:    misal = req_addr[0];
         2'd2:    misal = |req_addr[1:0];
         default: misal = |req_addr[2:0];
      endcase

      size_mask = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (i < (32'd1 << sz)) size_mask[i] = 1'b1;
      end
      be_d    = req_we ? (size_mask << req_off) : '1;
      wdata_d = req_wdata << {req_off, 3'b000};
      addr_d  = req_addr;
      addr_d[OFF_W-1:0] = '0;
   end

   // Load result: shift the addressed lane down, then extend by funct3
   logic [XLEN-1:0] shifted, load_ext;

   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
         3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
         3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
         3'b100:  load_ext = XLEN'(shifted[7:0]);
         3'b101:  load_ext = XLEN'(shifted[15:0]);
         3'b110:  load_ext = XLEN'(shifted[31:0]);
         default: load_ext = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wait_q      <= '0;
         funct3_q    <= '0;
         off_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  funct3_q    <= req_funct3;
                  off_q       <= req_off;
                  if (!legal || misal) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q     <= S_BUS;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_we;
                     mem_addr_q  <= addr_d;
                     mem_be_q    <= be_d;
                     mem_wdata_q <= wdata_d;
                     wait_q      <= '0;
                  end
               end
            end
            S_BUS: begin
               // An ack in the final wait cycle takes priority over the timeout
               if (mem_ack) begin
                  state_q     <= S_RESP;
                  mem_req_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= mem_we_q ? '0 : load_ext;
               end else if (wait_q + 8'd1 == 8'(MAX_WAIT)) begin
                  state_q     <= S_RESP;
                  mem_req_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  wait_q      <= wait_q + 8'd1;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            S_RESP: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule
